pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline sequencer and hazard controller for the 8-bit li/addi pipelined core.
- Owns the control-side pipeline registers (ID/EX, EX/WB): valid, ALUSrc, RegWrite, Rs, Rd.
- Drives the ALU's ALUSrc and Fwd_signal inputs and gates instruction fetch.
- Runs a fill/run/drain/halt state machine around the datapath.

Parameters:
- REG_ADDR_W, 3, register-file address width (8 registers).
- FILL_CYCLES, 2, number of bubble cycles issued after reset before decode output is trusted; legal range 1..7.

Ports:
- Clk  in  1  system clock, all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Instr_Valid  in  1  instruction memory has a valid instruction at decode this cycle.
- Dec_Is_Li  in  1  decoded instruction is li.
- Dec_Is_Addi  in  1  decoded instruction is addi.
- Dec_Is_Halt  in  1  decoded instruction is halt.
- Dec_Rs  in  REG_ADDR_W  decoded source register.
- Dec_Rd  in  REG_ADDR_W  decoded destination register.
- Fetch_En  out  1  PC increment / fetch enable.
- ID_EX_ALUSrc  out  1  to ALU ALUSrc: 0 = li, 1 = addi.
- ID_EX_RegWrite  out  1  EX-stage instruction writes a register.
- ID_EX_Rd  out  REG_ADDR_W  EX-stage destination.
- EX_WB_RegWrite  out  1  register-file write enable.
- EX_WB_Rd  out  REG_ADDR_W  register-file write address.
- Fwd_signal  out  1  to ALU: select EX_WB_Write_Data as operand.
- Busy  out  1  high in FILL, RUN or DRAIN.
- Halted  out  1  high in HALTED.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State = FILL; fill counter = 0.
  - All ID_EX/EX_WB fields = 0; Fwd_signal = 0.
  - Fetch_En = 0, Busy = 0, Halted = 0.
  - Outputs hold these values until the first rising edge after Reset returns to 1.
- FILL:
  - Fetch_En = 1, Busy = 1.
  - ID_EX is loaded with a bubble (valid = 0, RegWrite = 0, ALUSrc = 0, Rs = Rd = 0).
  - Counter increments each cycle; at FILL_CYCLES-1 the next state is RUN.
- RUN:
  - Fetch_En = Instr_Valid.
  - ID_EX captures the decode fields when Instr_Valid = 1 and Dec_Is_Halt = 0:
    - valid = 1
    - RegWrite = Dec_Is_Li | Dec_Is_Addi
    - ALUSrc = Dec_Is_Addi
    - Rs, Rd from decode
  - Otherwise ID_EX takes a bubble.
  - Instr_Valid = 1 with Dec_Is_Halt = 1: halt is not issued; state goes to DRAIN; Fetch_En = 0 from that cycle on.
- DRAIN:
  - Fetch_En = 0; bubbles are inserted for 2 cycles so in-flight EX and WB instructions complete.
  - Then state goes to HALTED.
- HALTED:
  - Fetch_En = 0, Busy = 0, Halted = 1.
  - All RegWrite = 0.
  - Only Reset exits this state.
- EX_WB advances every cycle in all states: EX_WB <= ID_EX (valid, RegWrite, Rd). There is no stall of the back end.
- Forwarding (combinational from registered state):
  - Fwd_signal = ID_EX_valid & ID_EX_ALUSrc & EX_WB_RegWrite & (ID_EX_Rs == EX_WB_Rd).
  - Never asserted for li or for bubbles.
  - Never asserted from a bubble in EX_WB, which always has RegWrite = 0.
- Simultaneous events:
  - Dec_Is_Halt together with Dec_Is_Li/Addi: halt wins.
  - Instr_Valid = 0 in RUN gives a bubble with no state change.
- Decode inputs are ignored in FILL, DRAIN and HALTED.
- Latency: a decoded instruction appears on the ID_EX_* outputs 1 cycle after capture and on EX_WB_* 2 cycles after capture.

Optional Feature:
- Macro: PIPE_CTRL_BUBBLE_CNT_EN.
- With the macro defined:
  - Adds output Bubble_Count, 16 bits.
  - Increments on every cycle a bubble is loaded into ID_EX while in RUN.
  - Saturates at 16'hFFFF.
  - Reset value 0 (asynchronous, with Reset).
- Without the macro: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset asserted mid-RUN with RegWrite = 1 in flight -> within the same cycle, before any clock edge, all outputs are 0 and Fwd_signal = 0. After release, 2 FILL cycles run with Fetch_En = 1 and ID_EX_RegWrite = 0, then Busy = 1 in RUN.
- li r1 then addi r2,r1 back-to-back -> in the cycle addi is in EX: ID_EX_ALUSrc = 1, EX_WB_Rd = 1, EX_WB_RegWrite = 1, Fwd_signal = 1.
- li r1 then addi r2,r3 -> Fwd_signal = 0. Then li r3 followed by li r3 -> Fwd_signal = 0 (li never forwards).
- li r1, then Instr_Valid = 0 for 1 cycle, then addi r2,r1 -> bubble in EX_WB, so Fwd_signal = 0. Bubble_Count = 1 when PIPE_CTRL_BUBBLE_CNT_EN is defined.
- addi r4,r4 then halt -> Fetch_En = 0 from the halt decode cycle. r4 write seen with EX_WB_RegWrite = 1 one cycle later. Halted = 1 and Busy = 0 two cycles after entering DRAIN. Further Dec_Is_Addi pulses cause no RegWrite.
- Instr_Valid = 1 with Dec_Is_Halt = 1 and Dec_Is_Li = 1 in the same cycle -> no ID_EX_RegWrite, state enters DRAIN.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: control-side pipeline sequencer and hazard controller for the 8-bit li/addi core.
// Owns the ID/EX and EX/WB control registers, drives ALUSrc/Fwd_signal to the ALU, gates fetch
// and runs a FILL -> RUN -> DRAIN -> HALTED sequence around the datapath.
// Optional build macro: PIPE_CTRL_BUBBLE_CNT_EN adds the 16-bit saturating Bubble_Count output.

module pipe_ctrl #(
  parameter int unsigned REG_ADDR_W  = 3,
  parameter int unsigned FILL_CYCLES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Instr_Valid,
  input  logic                  Dec_Is_Li,
  input  logic                  Dec_Is_Addi,
  input  logic                  Dec_Is_Halt,
  input  logic [REG_ADDR_W-1:0] Dec_Rs,
  input  logic [REG_ADDR_W-1:0] Dec_Rd,
  output logic                  Fetch_En,
  output logic                  ID_EX_ALUSrc,
  output logic                  ID_EX_RegWrite,
  output logic [REG_ADDR_W-1:0] ID_EX_Rd,
  output logic                  EX_WB_RegWrite,
  output logic [REG_ADDR_W-1:0] EX_WB_Rd,
  output logic                  Fwd_signal,
  output logic                  Busy,
  output logic                  Halted
`ifdef PIPE_CTRL_BUBBLE_CNT_EN
  ,
  output logic [15:0]           Bubble_Count
`endif
);

  typedef enum logic [1:0] {StFill, StRun, StDrain, StHalted} state_e;

  localparam logic [2:0] FillLast = 3'(FILL_CYCLES - 1);

  state_e                state_q;
  // Low only between reset release and the first clock edge, so outputs keep reset values.
  logic                  started_q;
  logic [2:0]            fill_cnt_q;
  logic                  drain_cnt_q;

  logic                  id_ex_valid_q;
  logic                  id_ex_alusrc_q;
  logic                  id_ex_regwrite_q;
  logic [REG_ADDR_W-1:0] id_ex_rs_q;
  logic [REG_ADDR_W-1:0] id_ex_rd_q;

  logic                  ex_wb_valid_q;
  logic                  ex_wb_regwrite_q;
  logic [REG_ADDR_W-1:0] ex_wb_rd_q;

  logic                  in_run;
  logic                  issue;
  logic                  halt_req;

  // Decode qualification: only RUN accepts instructions; halt is consumed, never issued.
  always_comb begin
    in_run   = started_q && (state_q == StRun);
    issue    = in_run && Instr_Valid && !Dec_Is_Halt;
    halt_req = in_run && Instr_Valid && Dec_Is_Halt;
  end

  // Sequencer FSM plus ID/EX and EX/WB control registers; the back end never stalls.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q          <= StFill;
      started_q        <= 1'b0;
      fill_cnt_q       <= '0;
      drain_cnt_q      <= 1'b0;
      id_ex_valid_q    <= 1'b0;
      id_ex_alusrc_q   <= 1'b0;
      id_ex_regwrite_q <= 1'b0;
      id_ex_rs_q       <= '0;
      id_ex_rd_q       <= '0;
      ex_wb_valid_q    <= 1'b0;
      ex_wb_regwrite_q <= 1'b0;
      ex_wb_rd_q       <= '0;
    end else begin
      started_q <= 1'b1;

      if (issue) begin
        id_ex_valid_q    <= 1'b1;
        id_ex_alusrc_q   <= Dec_Is_Addi;
        id_ex_regwrite_q <= Dec_Is_Li | Dec_Is_Addi;
        id_ex_rs_q       <= Dec_Rs;
        id_ex_rd_q       <= Dec_Rd;
      end else begin
        id_ex_valid_q    <= 1'b0;
        id_ex_alusrc_q   <= 1'b0;
        id_ex_regwrite_q <= 1'b0;
        id_ex_rs_q       <= '0;
        id_ex_rd_q       <= '0;
      end

      ex_wb_valid_q    <= id_ex_valid_q;
      ex_wb_regwrite_q <= id_ex_regwrite_q;
      ex_wb_rd_q       <= id_ex_rd_q;

      case (state_q)
        StFill: begin
          if (started_q) begin
            if (fill_cnt_q == FillLast) begin
              state_q    <= StRun;
              fill_cnt_q <= '0;
            end else begin
              fill_cnt_q <= fill_cnt_q + 3'd1;
            end
          end
        end
        StRun: begin
          if (halt_req) begin
            state_q     <= StDrain;
            drain_cnt_q <= 1'b0;
          end
        end
        StDrain: begin
          // Two bubble cycles let the in-flight EX and WB instructions retire.
          if (drain_cnt_q) begin
            state_q <= StHalted;
          end else begin
            drain_cnt_q <= 1'b1;
          end
        end
        StHalted: state_q <= StHalted;
        default:  state_q <= StFill;
      endcase
    end
  end

  // Outputs decoded from registered state; fetch also follows the live decode in RUN.
  always_comb begin
    Fetch_En       = started_q && ((state_q == StFill) || issue);
    Busy           = started_q && (state_q != StHalted);
    Halted         = (state_q == StHalted);
    ID_EX_ALUSrc   = id_ex_alusrc_q;
    ID_EX_RegWrite = id_ex_regwrite_q;
    ID_EX_Rd       = id_ex_rd_q;
    EX_WB_RegWrite = ex_wb_regwrite_q;
    EX_WB_Rd       = ex_wb_rd_q;
    Fwd_signal     = id_ex_valid_q && id_ex_alusrc_q && ex_wb_valid_q && ex_wb_regwrite_q &&
                     (id_ex_rs_q == ex_wb_rd_q);
  end

`ifdef PIPE_CTRL_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q;

  // Saturating count of RUN cycles that load a bubble into ID/EX.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bubble_cnt_q <= '0;
    end else if (in_run && !issue && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign Bubble_Count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, hand-written halt/reset sequences
// and randomized decode streams checked against a cycle-count based reference model.

module tb_pipe_ctrl;

  localparam int unsigned AW   = 3;
  localparam int          FILL = 2;

  localparam int MPre   = 0;
  localparam int MFill  = 1;
  localparam int MRun   = 2;
  localparam int MDrain = 3;
  localparam int MHalt  = 4;

  logic          Clk         = 1'b0;
  logic          Reset       = 1'b1;
  logic          Instr_Valid = 1'b0;
  logic          Dec_Is_Li   = 1'b0;
  logic          Dec_Is_Addi = 1'b0;
  logic          Dec_Is_Halt = 1'b0;
  logic [AW-1:0] Dec_Rs      = '0;
  logic [AW-1:0] Dec_Rd      = '0;
  logic          Fetch_En;
  logic          ID_EX_ALUSrc;
  logic          ID_EX_RegWrite;
  logic [AW-1:0] ID_EX_Rd;
  logic          EX_WB_RegWrite;
  logic [AW-1:0] EX_WB_Rd;
  logic          Fwd_signal;
  logic          Busy;
  logic          Halted;
`ifdef PIPE_CTRL_BUBBLE_CNT_EN
  logic [15:0]   Bubble_Count;
`endif

  pipe_ctrl #(
    .REG_ADDR_W (AW),
    .FILL_CYCLES(FILL)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Instr_Valid   (Instr_Valid),
    .Dec_Is_Li     (Dec_Is_Li),
    .Dec_Is_Addi   (Dec_Is_Addi),
    .Dec_Is_Halt   (Dec_Is_Halt),
    .Dec_Rs        (Dec_Rs),
    .Dec_Rd        (Dec_Rd),
    .Fetch_En      (Fetch_En),
    .ID_EX_ALUSrc  (ID_EX_ALUSrc),
    .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_Rd      (ID_EX_Rd),
    .EX_WB_RegWrite(EX_WB_RegWrite),
    .EX_WB_Rd      (EX_WB_Rd),
    .Fwd_signal    (Fwd_signal),
    .Busy          (Busy),
    .Halted        (Halted)
`ifdef PIPE_CTRL_BUBBLE_CNT_EN
    ,
    .Bubble_Count  (Bubble_Count)
`endif
  );

  always #5 Clk = ~Clk;

  // Reference model: a two-deep queue of issued instruction slots plus cycle bookkeeping.
  typedef struct packed {
    logic          valid;
    logic          alusrc;
    logic          rw;
    logic [AW-1:0] rs;
    logic [AW-1:0] rd;
  } slot_t;

  slot_t m_idex;
  slot_t m_exwb;
  int    m_cyc;
  int    m_halt;
  int    m_bub;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int iv, li, addi, halt, rs, rd;
    int fe, alusrc, idrw, idrd, wbrw, wbrd, fwd, busy, halted;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Cycle 0 follows reset release, cycles 1..FILL fill, RUN until the halt cycle, then 2 drain.
  function automatic int mode();
    if (m_cyc == 0) return MPre;
    if (m_cyc <= FILL) return MFill;
    if (m_halt < 0 || m_cyc <= m_halt) return MRun;
    if (m_cyc <= m_halt + 2) return MDrain;
    return MHalt;
  endfunction

  task automatic model_reset();
    m_idex = '0;
    m_exwb = '0;
    m_cyc  = 0;
    m_halt = -1;
    m_bub  = 0;
  endtask

  task automatic check_model();
    int   md;
    logic efe;
    logic efwd;
    md   = mode();
    efe  = (md == MFill) || (md == MRun && Instr_Valid && !Dec_Is_Halt);
    efwd = m_idex.valid && m_idex.alusrc && m_exwb.rw && (m_idex.rs == m_exwb.rd);
    chk("model Fetch_En", Fetch_En, efe);
    chk("model ID_EX_ALUSrc", ID_EX_ALUSrc, m_idex.alusrc);
    chk("model ID_EX_RegWrite", ID_EX_RegWrite, m_idex.rw);
    chk("model ID_EX_Rd", ID_EX_Rd, m_idex.rd);
    chk("model EX_WB_RegWrite", EX_WB_RegWrite, m_exwb.rw);
    chk("model EX_WB_Rd", EX_WB_Rd, m_exwb.rd);
    chk("model Fwd_signal", Fwd_signal, efwd);
    chk("model Busy", Busy, (md == MFill) || (md == MRun) || (md == MDrain));
    chk("model Halted", Halted, md == MHalt);
`ifdef PIPE_CTRL_BUBBLE_CNT_EN
    chk("model Bubble_Count", Bubble_Count, (m_bub > 65535) ? 65535 : m_bub);
`endif
  endtask

  task automatic model_update();
    int    md;
    slot_t n;
    md = mode();
    n  = '0;
    if (md == MRun) begin
      if (Instr_Valid && !Dec_Is_Halt) begin
        n.valid  = 1'b1;
        n.alusrc = Dec_Is_Addi;
        n.rw     = Dec_Is_Li | Dec_Is_Addi;
        n.rs     = Dec_Rs;
        n.rd     = Dec_Rd;
      end else begin
        m_bub++;
      end
      if (Instr_Valid && Dec_Is_Halt) m_halt = m_cyc;
    end
    m_exwb = m_idex;
    m_idex = n;
    m_cyc++;
  endtask

  // Apply decode inputs in the low phase, then compare against the model before the edge.
  task automatic drive(input int iv, input int li, input int addi, input int halt,
                       input int rs, input int rd);
    @(negedge Clk);
    Instr_Valid = (iv != 0);
    Dec_Is_Li   = (li != 0);
    Dec_Is_Addi = (addi != 0);
    Dec_Is_Halt = (halt != 0);
    Dec_Rs      = AW'(rs);
    Dec_Rd      = AW'(rd);
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge Clk);
    model_update();
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    model_reset();
    #1;
    chk("reset Fetch_En", Fetch_En, 0);
    chk("reset ID_EX_ALUSrc", ID_EX_ALUSrc, 0);
    chk("reset ID_EX_RegWrite", ID_EX_RegWrite, 0);
    chk("reset ID_EX_Rd", ID_EX_Rd, 0);
    chk("reset EX_WB_RegWrite", EX_WB_RegWrite, 0);
    chk("reset EX_WB_Rd", EX_WB_Rd, 0);
    chk("reset Fwd_signal", Fwd_signal, 0);
    chk("reset Busy", Busy, 0);
    chk("reset Halted", Halted, 0);
    Instr_Valid = 1'b0;
    Dec_Is_Li   = 1'b0;
    Dec_Is_Addi = 1'b0;
    Dec_Is_Halt = 1'b0;
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b1;
  endtask

  // Post-reset cycle, FILL cycles with live-looking decode that must be ignored, first RUN cycle.
  task automatic to_run();
    drive(1, 0, 1, 0, 1, 1);
    chk("pre Fetch_En", Fetch_En, 0);
    chk("pre Busy", Busy, 0);
    tick();
    for (int i = 0; i < FILL; i++) begin
      drive(1, 1, 0, 0, 2, 2);
      chk("fill Fetch_En", Fetch_En, 1);
      chk("fill ID_EX_RegWrite", ID_EX_RegWrite, 0);
      chk("fill Busy", Busy, 1);
      tick();
    end
  endtask

  initial begin
    // iv li addi halt rs rd | fe alusrc idrw idrd wbrw wbrd fwd busy halted
    tbl[0]  = '{1, 1, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[1]  = '{1, 0, 1, 0, 1, 2,  1, 0, 1, 1, 0, 0, 0, 1, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 1,  1, 1, 1, 2, 1, 1, 1, 1, 0};
    tbl[3]  = '{1, 0, 1, 0, 3, 2,  1, 0, 1, 1, 1, 2, 0, 1, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 3,  1, 1, 1, 2, 1, 1, 0, 1, 0};
    tbl[5]  = '{1, 1, 0, 0, 3, 3,  1, 0, 1, 3, 1, 2, 0, 1, 0};
    tbl[6]  = '{1, 1, 0, 0, 0, 1,  1, 0, 1, 3, 1, 3, 0, 1, 0};
    tbl[7]  = '{0, 0, 1, 0, 1, 2,  0, 0, 1, 1, 1, 3, 0, 1, 0};
    tbl[8]  = '{1, 0, 1, 0, 1, 2,  1, 0, 0, 0, 1, 1, 0, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0,  0, 1, 1, 2, 0, 0, 0, 1, 0};
    tbl[10] = '{1, 1, 0, 1, 0, 5,  0, 0, 0, 0, 1, 2, 0, 1, 0};
    tbl[11] = '{1, 0, 1, 0, 4, 4,  0, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[12] = '{1, 0, 1, 0, 4, 4,  0, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[13] = '{1, 0, 1, 0, 4, 4,  0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[14] = '{1, 0, 1, 0, 4, 4,  0, 0, 0, 0, 0, 0, 0, 0, 1};

    #2;
    do_reset();
    to_run();
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].iv, tbl[i].li, tbl[i].addi, tbl[i].halt, tbl[i].rs, tbl[i].rd);
      chk($sformatf("row%0d Fetch_En", i), Fetch_En, tbl[i].fe);
      chk($sformatf("row%0d ID_EX_ALUSrc", i), ID_EX_ALUSrc, tbl[i].alusrc);
      chk($sformatf("row%0d ID_EX_RegWrite", i), ID_EX_RegWrite, tbl[i].idrw);
      chk($sformatf("row%0d ID_EX_Rd", i), ID_EX_Rd, tbl[i].idrd);
      chk($sformatf("row%0d EX_WB_RegWrite", i), EX_WB_RegWrite, tbl[i].wbrw);
      chk($sformatf("row%0d EX_WB_Rd", i), EX_WB_Rd, tbl[i].wbrd);
      chk($sformatf("row%0d Fwd_signal", i), Fwd_signal, tbl[i].fwd);
      chk($sformatf("row%0d Busy", i), Busy, tbl[i].busy);
      chk($sformatf("row%0d Halted", i), Halted, tbl[i].halted);
      tick();
    end

    // addi r4,r4 then halt: r4 still retires, then drain into HALTED.
    do_reset();
    to_run();
    drive(1, 0, 1, 0, 4, 4);
    tick();
    drive(1, 0, 0, 1, 0, 0);
    chk("halt Fetch_En", Fetch_En, 0);
    chk("halt ID_EX_Rd", ID_EX_Rd, 4);
    tick();
    drive(1, 0, 1, 0, 4, 4);
    chk("drain1 EX_WB_RegWrite", EX_WB_RegWrite, 1);
    chk("drain1 EX_WB_Rd", EX_WB_Rd, 4);
    chk("drain1 Busy", Busy, 1);
    tick();
    drive(1, 0, 1, 0, 4, 4);
    chk("drain2 Halted", Halted, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 0, 4, 4);
      chk("halted Halted", Halted, 1);
      chk("halted Busy", Busy, 0);
      chk("halted ID_EX_RegWrite", ID_EX_RegWrite, 0);
      chk("halted EX_WB_RegWrite", EX_WB_RegWrite, 0);
      tick();
    end

    // Asynchronous reset mid-RUN with writes in flight in both stages.
    do_reset();
    to_run();
    drive(1, 1, 0, 0, 0, 5);
    tick();
    drive(1, 1, 0, 0, 0, 6);
    tick();
    drive(1, 0, 1, 0, 6, 7);
    chk("inflight ID_EX_RegWrite", ID_EX_RegWrite, 1);
    chk("inflight EX_WB_RegWrite", EX_WB_RegWrite, 1);
    do_reset();
    to_run();
    drive(0, 0, 0, 0, 0, 0);
    chk("rerun Busy", Busy, 1);
    tick();

    // Randomized decode streams, with occasional halts and an async reset mid-stream.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      to_run();
      for (int c = 0; c < 100; c++) begin
        if (r == 2 && c == 50) begin
          do_reset();
          to_run();
        end
        drive(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1), $urandom_range(0, 1),
              ($urandom_range(0, 59) == 0) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 7));
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
